// File: rtl/z_result_stage_if.sv
// Result-bus handshake between z_result_stage (master) and its bus consumer (slave).
// A word moves on every cycle where out_valid and out_ready are both high.
interface z_result_stage_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_is_hi;

    modport master (
        output out_valid,
        output out_data,
        output out_is_hi,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_is_hi,
        output out_ready
    );
endinterface

// File: rtl/z_result_stage.sv
// Z result stage: captures the 2*DATA_W ALU result into ZHI:ZLO and streams it onto the bus.
// Optional result flags (z_zero/z_neg) are built only when Z_FLAGS_EN is defined.
module z_result_stage #(
    parameter int DATA_W = 32,
    parameter int MUL_OP = 10
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [2*DATA_W-1:0]   alu_c,
    input  logic [4:0]            alu_op,
    input  logic                  load_z,
    output logic                  z_busy,
    output logic [DATA_W-1:0]     z_hi,
    output logic [DATA_W-1:0]     z_lo,
    output logic                  overrun,
    output logic                  z_zero,
    output logic                  z_neg,
    z_result_stage_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO_BEAT = 2'd1,
        HI_BEAT = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   is_mul;
    logic   capture;
    logic   accept;

    // Captures happen only from IDLE; a load_z while busy never touches Z.
    assign capture = (state == IDLE) && load_z;
    assign accept  = bus.out_valid && bus.out_ready;
    assign z_busy  = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted first so no path through this block infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (load_z) begin
                    next_state = LO_BEAT;
                end
            end
            LO_BEAT: begin
                if (accept) begin
                    next_state = is_mul ? HI_BEAT : IDLE;
                end
            end
            HI_BEAT: begin
                if (accept) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus outputs decode straight from registered state, so they hold steady under backpressure.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_is_hi = 1'b0;
        bus.out_data  = z_lo;
        unique case (state)
            LO_BEAT: begin
                bus.out_valid = 1'b1;
            end
            HI_BEAT: begin
                bus.out_valid = 1'b1;
                bus.out_is_hi = 1'b1;
                bus.out_data  = z_hi;
            end
            default: begin
                bus.out_valid = 1'b0;
            end
        endcase
    end

    // NOTE: Z is a plain register pair, not a memory, so it takes the async reset like any other state.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z_hi   <= '0;
            z_lo   <= '0;
            is_mul <= 1'b0;
        end else if (capture) begin
            z_hi   <= alu_c[2*DATA_W-1:DATA_W];
            z_lo   <= alu_c[DATA_W-1:0];
            is_mul <= (alu_op == 5'(MUL_OP));
        end
    end

    // Sticky until reset; includes a load coinciding with the final accepted beat.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            overrun <= 1'b0;
        end else if (load_z && z_busy) begin
            overrun <= 1'b1;
        end
    end

`ifdef Z_FLAGS_EN
    logic zero_q;
    logic neg_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (capture) begin
            if (alu_op == 5'(MUL_OP)) begin
                zero_q <= (alu_c == '0);
                neg_q  <= alu_c[2*DATA_W-1];
            end else begin
                zero_q <= (alu_c[DATA_W-1:0] == '0);
                neg_q  <= alu_c[DATA_W-1];
            end
        end
    end

    assign z_zero = zero_q;
    assign z_neg  = neg_q;
`else
    assign z_zero = 1'b0;
    assign z_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Scoreboard bench for z_result_stage: stimulus pushes expected bus beats, a monitor pops on each handshake.
// Flag expectations follow the Z_FLAGS_EN build option.
module tb_z_result_stage;

    localparam int DATA_W = 32;

    logic                clock;
    logic                clear;
    logic [2*DATA_W-1:0] alu_c;
    logic [4:0]          alu_op;
    logic                load_z;
    logic                z_busy;
    logic [DATA_W-1:0]   z_hi;
    logic [DATA_W-1:0]   z_lo;
    logic                overrun;
    logic                z_zero;
    logic                z_neg;

    z_result_stage_if #(.DATA_W(DATA_W)) bus ();

    z_result_stage #(.DATA_W(DATA_W), .MUL_OP(10)) dut (
        .clock   (clock),
        .clear   (clear),
        .alu_c   (alu_c),
        .alu_op  (alu_op),
        .load_z  (load_z),
        .z_busy  (z_busy),
        .z_hi    (z_hi),
        .z_lo    (z_lo),
        .overrun (overrun),
        .z_zero  (z_zero),
        .z_neg   (z_neg),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q[$];   // {is_hi, data}

`ifdef Z_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the oldest expected beat.
    always @(negedge clock) begin
        if (clear && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {31'd0, bus.out_is_hi, bus.out_data}, 64'hDEAD);
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                check("beat", {31'd0, bus.out_is_hi, bus.out_data}, {31'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [63:0] c, input logic [4:0] op);
        alu_c  = c;
        alu_op = op;
        load_z = 1'b1;
        cycle();
        load_z = 1'b0;
    endtask

    task automatic push(input logic hi, input logic [31:0] d);
        exp_q.push_back({hi, d});
    endtask

    initial begin
        clear         = 1'b0;
        alu_c         = '0;
        alu_op        = '0;
        load_z        = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'd0, z_busy}, 64'd0);
        check("rst_z", {z_hi, z_lo}, 64'd0);
        check("rst_flags", {61'd0, overrun, z_zero, z_neg}, 64'd0);
        #9 clear = 1'b1;
        cycle();

        // 1. single-word add
        bus.out_ready = 1'b1;
        push(1'b0, 32'd5);
        load(64'h0000_0000_0000_0005, 5'd2);
        check("add_valid", {63'd0, bus.out_valid}, 64'd1);
        check("add_data", {32'd0, bus.out_data}, 64'd5);
        check("add_is_hi", {63'd0, bus.out_is_hi}, 64'd0);
        check("add_busy", {63'd0, z_busy}, 64'd1);
        cycle();
        check("add_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        check("add_idle_busy", {63'd0, z_busy}, 64'd0);

        // 2. multiply, two beats back to back
        push(1'b0, 32'h8000_0000);
        push(1'b1, 32'h0000_0001);
        load(64'h0000_0001_8000_0000, 5'd10);
        check("mul_lo_data", {32'd0, bus.out_data}, 64'h8000_0000);
        cycle();
        check("mul_hi_data", {32'd0, bus.out_data}, 64'h1);
        check("mul_hi_flag", {63'd0, bus.out_is_hi}, 64'd1);
        cycle();
        check("mul_idle", {62'd0, bus.out_valid, z_busy}, 64'd0);
        check("mul_z_kept", {z_hi, z_lo}, 64'h0000_0001_8000_0000);
        check("no_overrun", {63'd0, overrun}, 64'd0);

        // unknown opcode is one beat
        push(1'b0, 32'h0000_0077);
        load(64'hAAAA_BBBB_0000_0077, 5'd31);
        cycle();
        check("unk_one_beat", {63'd0, z_busy}, 64'd0);

        // 3. backpressure on a multiply
        bus.out_ready = 1'b0;
        load(64'h1234_5678_9ABC_DEF0, 5'd10);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_data", {32'd0, bus.out_data}, 64'h9ABC_DEF0);
            check("bp_is_hi", {63'd0, bus.out_is_hi}, 64'd0);
            cycle();
        end
        push(1'b0, 32'h9ABC_DEF0);
        push(1'b1, 32'h1234_5678);
        bus.out_ready = 1'b1;
        cycle();
        check("bp_hi_data", {32'd0, bus.out_data}, 64'h1234_5678);
        cycle();
        check("bp_done", {63'd0, z_busy}, 64'd0);

        // load coinciding with the last accepted beat is dropped
        bus.out_ready = 1'b0;
        push(1'b0, 32'h11);
        load(64'h0000_0000_0000_0011, 5'd2);
        bus.out_ready = 1'b1;
        load(64'h0000_0000_0000_0022, 5'd2);
        check("coinc_idle", {63'd0, z_busy}, 64'd0);
        check("coinc_z", {z_hi, z_lo}, 64'h11);
        check("coinc_overrun", {63'd0, overrun}, 64'd1);

        // 4. overrun mid-beat
        bus.out_ready = 1'b0;
        push(1'b0, 32'h33);
        load(64'h0000_0000_0000_0033, 5'd2);
        load(64'h5555_5555_0000_0044, 5'd10);
        check("ovr_z", {z_hi, z_lo}, 64'h33);
        check("ovr_data", {32'd0, bus.out_data}, 64'h33);
        check("ovr_busy", {63'd0, z_busy}, 64'd1);
        bus.out_ready = 1'b1;
        cycle();
        check("ovr_sticky", {62'd0, overrun, z_busy}, 64'd2);

        // 5. asynchronous reset during HI_BEAT
        push(1'b0, 32'h3);
        load(64'h0000_0002_0000_0003, 5'd10);
        cycle();
        bus.out_ready = 1'b0;
        check("rst_pre_hi", {31'd0, bus.out_is_hi, bus.out_data}, 64'h1_0000_0002);
        #2 clear = 1'b0;
        #1;
        check("arst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_z", {z_hi, z_lo}, 64'd0);
        check("arst_state", {62'd0, overrun, z_busy}, 64'd0);
        #2 clear = 1'b1;
        cycle();
        check("arst_stay_idle", {63'd0, bus.out_valid}, 64'd0);

        // 6. result flags
        bus.out_ready = 1'b1;
        push(1'b0, 32'hFFFF_FFFE);
        load(64'hFFFF_FFFF_FFFF_FFFE, 5'd3);
        check("flag_sub", {62'd0, z_zero, z_neg}, {62'd0, 1'b0, FLAGS});
        cycle();
        push(1'b0, 32'h0);
        load(64'h0, 5'd4);
        check("flag_or0", {62'd0, z_zero, z_neg}, {62'd0, FLAGS, 1'b0});
        cycle();
        push(1'b0, 32'h0);
        push(1'b1, 32'h8000_0000);
        load(64'h8000_0000_0000_0000, 5'd10);
        check("flag_mul", {62'd0, z_zero, z_neg}, {62'd0, 1'b0, FLAGS});
        cycle();
        cycle();
        check("flag_hold", {62'd0, z_zero, z_neg}, {62'd0, 1'b0, FLAGS});

        cycle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
